// File: rtl/cdc_bus_scheduler.sv
// Shares one data_synchronizer crossing among NUM_REQ requesters: arbitrate, latch word, then SETUP/HOLD/GAP on bus_enable.
// Transfer period 2+HOLD_CYCLES+GAP_CYCLES; requesters hold req until ack. `CDC_SCHED_FIXED_PRIO_EN selects fixed priority over round robin.
module cdc_bus_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [BUS_WIDTH-1:0]           unsync_bus,
  output logic                           bus_enable,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [BUS_WIDTH-1:0]   bus_q, bus_d;
  logic                   bus_en_q, bus_en_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [ID_W-1:0]        base;
  logic                   win_vld;
  logic [ID_W-1:0]        win_id;
  logic [ID_W:0]          sum;
  logic [ID_W-1:0]        cand;
  logic [BUS_WIDTH-1:0]   words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
  end

`ifdef CDC_SCHED_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  assign base = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && win_vld) begin
      ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  // Scan starting at base, wrapping modulo NUM_REQ; first set req wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, base} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    bus_d   = bus_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          ack_d[win_id] = 1'b1;
          bus_d         = words[win_id];
          grant_d       = win_id;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of the phase being entered.
    bus_en_d = (state_d == HOLD);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_q    <= '0;
      bus_q    <= '0;
      bus_en_q <= 1'b0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      bus_q    <= bus_d;
      bus_en_q <= bus_en_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign unsync_bus = bus_q;
  assign bus_enable = bus_en_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;

endmodule
